gshare_predictor: RTL and testbench

- Parametrised gshare direction predictor; next generation of the global-history branch predictor.
- Speculative global history register (GHR) XOR'd with PC bits indexes a pattern history table (PHT) of saturating counters.
- Adds registered lookup, checkpointed history recovery on mispredict, and a post-reset PHT init sweep.
- Sits beside fetch: fetch issues lookups; the branch unit returns resolved outcomes.

---
 rtl/gshare_predictor.sv | 134 +++++++++++++
 tb/tb_gshare_predictor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with registered lookup, checkpointed GHR recovery and PHT init sweep
// Optional feature macro: GSHARE_UPD_BYPASS_EN (same-cycle update-to-lookup forwarding)
module gshare_predictor #(
    parameter int GHR_W  = 12,
    parameter int CTR_W  = 2,
    parameter int PC_W   = 32,
    parameter int PC_LSB = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             pred_en,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_idx,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_en,
    input  logic [GHR_W-1:0] upd_idx,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispredict
);

    typedef enum logic {INIT, RUN} state_t;

    localparam int PHT_N = 1 << GHR_W;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CTR_W-1:0] pht [PHT_N];
    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] eghr;
    logic [GHR_W-1:0] init_ptr;
    logic [GHR_W-1:0] lkp_idx;
    logic             lkp_fire;
    logic             upd_fire;
    logic             recover;
    logic [CTR_W-1:0] upd_old;
    logic [CTR_W-1:0] upd_new;
    logic [CTR_W-1:0] rd_ctr;
    logic             unused_ok;

    // Only the indexing slice of the PC and the low history bits are consumed.
    assign unused_ok = ^{pred_pc, upd_ghr[GHR_W-1]};

    // State register: reset always restarts the init sweep.
    always_ff @(posedge clk) begin
        if (!rst) state <= INIT;
        else      state <= state_nxt;
    end

    // Next state: leave INIT once the last PHT entry has been written.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            INIT: if (&init_ptr) state_nxt = RUN;
            RUN:  ready = 1'b1;
            default: state_nxt = INIT;
        endcase
    end

    assign lkp_fire = ready && pred_en;
    assign upd_fire = ready && upd_en;
    assign recover  = upd_fire && upd_mispredict;

    // Effective history: recovery wins over the speculative shift of a response leaving this cycle.
    always_comb begin
        eghr = ghr;
        if (recover)         eghr = {upd_ghr[GHR_W-2:0], upd_taken};
        else if (pred_valid) eghr = {ghr[GHR_W-2:0], pred_taken};
    end

    assign lkp_idx = pred_pc[PC_LSB +: GHR_W] ^ eghr;
    assign upd_old = pht[upd_idx];

    // Saturating counter step for the resolved branch.
    always_comb begin
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != CTR_MAX) upd_new = upd_old + 1'b1;
        end else begin
            if (upd_old != '0) upd_new = upd_old - 1'b1;
        end
    end

    // Counter seen by the lookup; optionally forwards a same-index update.
    always_comb begin
        rd_ctr = pht[lkp_idx];
`ifdef GSHARE_UPD_BYPASS_EN
        if (upd_fire && (upd_idx == lkp_idx)) rd_ctr = upd_new;
`endif
    end

    // History register and init sweep pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr      <= '0;
            init_ptr <= '0;
        end else begin
            if (state == INIT) init_ptr <= init_ptr + 1'b1;
            ghr <= eghr;
        end
    end

    // Registered lookup response; index and checkpoint travel with the branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_idx   <= '0;
            pred_ghr   <= '0;
        end else begin
            pred_valid <= lkp_fire;
            if (lkp_fire) begin
                pred_taken <= rd_ctr[CTR_W-1];
                pred_idx   <= lkp_idx;
                pred_ghr   <= eghr;
            end
        end
    end

    // PHT write port: init sweep in INIT, resolved-branch updates in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == INIT)  pht[init_ptr] <= CTR_WEAK_NT;
            else if (upd_fire)  pht[upd_idx]  <= upd_new;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - scoreboard bench for gshare_predictor (GHR_W=4, CTR_W=2)
module tb_gshare_predictor;

    localparam int GW = 4;
    localparam int NE = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic          pred_en;
    logic [31:0]   pred_pc;
    logic          pred_valid;
    logic          pred_taken;
    logic [GW-1:0] pred_idx;
    logic [GW-1:0] pred_ghr;
    logic          upd_en;
    logic [GW-1:0] upd_idx;
    logic [GW-1:0] upd_ghr;
    logic          upd_taken;
    logic          upd_mispredict;

    gshare_predictor #(.GHR_W(GW), .CTR_W(2), .PC_W(32), .PC_LSB(2)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .pred_en(pred_en), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          taken;
        logic [GW-1:0] idx;
        logic [GW-1:0] ghr;
        int            due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    int   pht_m[NE];
    int   ghr_m;
    bit   pend_v;
    bit   pend_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int ctr_step(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (pred_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got pred_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("resp_latency", cyc, mon_e.due);
                chk("pred_taken", pred_taken, mon_e.taken);
                chk("pred_idx", pred_idx, mon_e.idx);
                chk("pred_ghr", pred_ghr, mon_e.ghr);
            end
        end
    end

    // One RUN cycle: drive inputs, advance the reference model, push expectation.
    task automatic step(input bit pe, input logic [31:0] pc, input bit ue, input int ui,
                        input int ug, input bit ut, input bit um);
        int  eg;
        int  idx;
        int  c;
        bit  tk;
        exp_t e;
        pred_en = pe; pred_pc = pc; upd_en = ue; upd_idx = GW'(ui);
        upd_ghr = GW'(ug); upd_taken = ut; upd_mispredict = um;
        if (ue && um)    eg = ((ug * 2) + ut) % NE;
        else if (pend_v) eg = ((ghr_m * 2) + pend_t) % NE;
        else             eg = ghr_m;
        tk = 1'b0;
        if (pe) begin
            idx = ((pc >> 2) % NE) ^ eg;
            c = pht_m[idx];
`ifdef GSHARE_UPD_BYPASS_EN
            if (ue && ui == idx) c = ctr_step(c, ut);
`endif
            tk = (c >= 2);
            e.taken = tk; e.idx = GW'(idx); e.ghr = GW'(eg); e.due = cyc + 1;
            q.push_back(e);
        end
        if (ue) pht_m[ui] = ctr_step(pht_m[ui], ut);
        ghr_m  = eg;
        pend_v = pe;
        pend_t = tk;
        @(posedge clk);
        #1;
        pred_en = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0;
    endtask

    // Reset, optionally re-reset mid-sweep at pointer 7, then time the sweep.
    task automatic do_reset(input bit abort_mid);
        int n;
        rst = 1'b0; pred_en = 1'b0; upd_en = 1'b0; upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_idx", pred_idx, 0);
        chk("rst_pred_ghr", pred_ghr, 0);
        for (int i = 0; i < NE; i++) pht_m[i] = 1;
        ghr_m = 0; pend_v = 1'b0; pend_t = 1'b0;
        q.delete();
        rst = 1'b1;
        if (abort_mid) begin
            repeat (7) @(posedge clk);
            #1;
            chk("mid_init_ready", ready, 0);
            rst = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
        end
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (ready === 1'b1) break;
        end
        chk("init_cycles", n, NE);
    endtask

    initial begin
        int pc;
        rst = 1'b0; pred_en = 1'b0; pred_pc = '0; upd_en = 1'b0; upd_idx = '0;
        upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        ghr_m = 0; pend_v = 1'b0; pend_t = 1'b0;
        for (int i = 0; i < NE; i++) pht_m[i] = 1;

        // Reset then first lookup at PC 0.
        do_reset(1'b0);
        step(1, 32'h0, 0, 0, 0, 0, 0);
        chk("first_taken", pred_taken, 0);
        chk("first_idx", pred_idx, 0);
        chk("first_ghr", pred_ghr, 0);

        // Reset during the sweep restarts it.
        do_reset(1'b1);

        // Saturation up then down on idx 5.
        repeat (3) step(0, 0, 1, 5, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        pc = (5 ^ ghr_m) << 2;
        step(1, pc, 0, 0, 0, 0, 0);
        chk("sat_hi_taken", pred_taken, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 1, 5, 0, 0, 0);
        pc = (5 ^ ghr_m) << 2;
        step(1, pc, 0, 0, 0, 0, 0);
        chk("sat_lo_taken", pred_taken, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Back-to-back lookups see each other's history.
        do_reset(1'b0);
        repeat (2) step(0, 0, 1, 1, 0, 1, 0);
        step(1, 32'h4, 0, 0, 0, 0, 0);
        chk("b2b_first_ghr", pred_ghr, 4'b0000);
        chk("b2b_first_taken", pred_taken, 1);
        step(1, 32'h8, 0, 0, 0, 0, 0);
        chk("b2b_second_ghr", pred_ghr, 4'b0001);
        chk("b2b_second_idx", pred_idx, 4'h3);

        // Mispredict coinciding with a response and a new lookup.
        step(1, 32'h0, 1, 3, 4'b0110, 1, 1);
        chk("recover_ghr", pred_ghr, 4'b1101);
        chk("recover_idx", pred_idx, 4'hd);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Same-cycle lookup and update on idx 9.
        pc = (9 ^ ghr_m) << 2;
        step(1, pc, 1, 9, 0, 1, 0);
`ifdef GSHARE_UPD_BYPASS_EN
        chk("bypass_taken", pred_taken, 1);
`else
        chk("rbw_taken", pred_taken, 0);
`endif
        step(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) != 0, $urandom, $urandom % 2, $urandom % NE,
                 $urandom % NE, $urandom % 2, ($urandom % 4) == 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain_queue", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
